// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative RV32M multiply/divide sequencer
module muldiv_sequencer #(
  parameter int INSTRUCTION_LEN = 32,
  parameter int N               = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [INSTRUCTION_LEN-1:0] instruction,
  input  logic [N-1:0]               data_1,
  input  logic [N-1:0]               data_2,
  output logic                       busy,
  output logic                       done,
  output logic [N-1:0]               data_out,
  output logic                       illegal
);

  localparam int CW = $clog2(N + 1);

  localparam logic [6:0] OPCODE_OP = 7'd51;
  localparam logic [6:0] FUNCT7_M  = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  // Architectural state
  state_t          state_q;
  logic [CW-1:0]   count_q;
  logic [2:0]      funct3_q;
  logic            sign_q;      // product / quotient sign
  logic            rsign_q;     // remainder sign (dividend sign)
  logic [N-1:0]    opnd_q;      // multiplicand for multiply, divisor for divide
  logic [2*N-1:0]  acc_q;       // product accumulator; low half is dividend/quotient for divide
  logic [N:0]      rem_q;       // partial remainder
  logic            busy_q;
  logic            done_q;
  logic            illegal_q;
  logic [N-1:0]    data_out_q;

  // Decode of the request presented in the start cycle
  logic [6:0]      opcode_in;
  logic [6:0]      funct7_in;
  logic [2:0]      funct3_in;
  logic            is_mop;
  logic            is_div_in;
  logic            a_signed_in;
  logic            b_signed_in;
  logic            a_neg_in;
  logic            b_neg_in;
  logic [N-1:0]    a_mag_in;
  logic [N-1:0]    b_mag_in;
  logic            div_zero_in;
  logic            div_ovf_in;
  logic            special_in;
  logic [N-1:0]    special_res_in;

  // Per-iteration next values
  logic [N:0]      mul_sum_d;
  logic [2*N-1:0]  mul_acc_d;
  logic [N:0]      div_shift_d;
  logic [N:0]      div_diff_d;
  logic [N:0]      div_rem_d;
  logic [N-1:0]    div_quo_d;

  // Sign-corrected result
  logic [2*N-1:0]  prod_fix_d;
  logic [N-1:0]    quo_fix_d;
  logic [N-1:0]    rem_fix_d;
  logic [N-1:0]    result_d;

  // Register-number fields are not needed here
  logic            unused_fields;
  assign unused_fields = ^{instruction[24:15], instruction[11:7]};

  // Decode the instruction and prepare operand magnitudes and special-case results
  always_comb begin
    opcode_in   = instruction[6:0];
    funct7_in   = instruction[31:25];
    funct3_in   = instruction[14:12];
    is_mop      = (opcode_in == OPCODE_OP) && (funct7_in == FUNCT7_M);
    is_div_in   = funct3_in[2];
    a_signed_in = (funct3_in == F3_MULH) || (funct3_in == F3_MULHSU) ||
                  (funct3_in == F3_DIV)  || (funct3_in == F3_REM);
    b_signed_in = (funct3_in == F3_MULH) || (funct3_in == F3_DIV) ||
                  (funct3_in == F3_REM);
    a_neg_in    = a_signed_in && data_1[N-1];
    b_neg_in    = b_signed_in && data_2[N-1];
    a_mag_in    = a_neg_in ? -data_1 : data_1;
    b_mag_in    = b_neg_in ? -data_2 : data_2;
    div_zero_in = is_div_in && (data_2 == '0);
    // Only the most negative dividend over -1 overflows a signed divide
    div_ovf_in  = is_div_in && b_signed_in &&
                  (data_1 == {1'b1, {(N-1){1'b0}}}) && (data_2 == '1);
    special_in  = div_zero_in || div_ovf_in;
    if (div_zero_in) begin
      special_res_in = funct3_in[1] ? data_1 : '1;
    end else begin
      special_res_in = funct3_in[1] ? '0 : data_1;
    end
  end

  // One shift-add multiply step and one restoring divide step
  always_comb begin
    mul_sum_d   = {1'b0, acc_q[2*N-1:N]} + {1'b0, (acc_q[0] ? opnd_q : {N{1'b0}})};
    mul_acc_d   = {mul_sum_d, acc_q[N-1:1]};
    div_shift_d = {rem_q[N-1:0], acc_q[N-1]};
    div_diff_d  = div_shift_d - {1'b0, opnd_q};
    if (!div_diff_d[N]) begin
      div_rem_d = div_diff_d;
      div_quo_d = {acc_q[N-2:0], 1'b1};
    end else begin
      div_rem_d = div_shift_d;
      div_quo_d = {acc_q[N-2:0], 1'b0};
    end
  end

  // Apply sign correction and select the architectural result
  always_comb begin
    prod_fix_d = sign_q  ? -acc_q : acc_q;
    quo_fix_d  = sign_q  ? -acc_q[N-1:0] : acc_q[N-1:0];
    rem_fix_d  = rsign_q ? -rem_q[N-1:0] : rem_q[N-1:0];
    case (funct3_q)
      F3_MUL:                        result_d = acc_q[N-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  result_d = prod_fix_d[2*N-1:N];
      F3_DIV, F3_DIVU:               result_d = quo_fix_d;
      F3_REM, F3_REMU:               result_d = rem_fix_d;
      default:                       result_d = '0;
    endcase
  end

  // Sequencer FSM with registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      funct3_q   <= '0;
      sign_q     <= 1'b0;
      rsign_q    <= 1'b0;
      opnd_q     <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      data_out_q <= '0;
    end else begin
      illegal_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (!is_mop) begin
              illegal_q <= 1'b1;
            end else if (special_in) begin
              data_out_q <= special_res_in;
              done_q     <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= S_DONE;
            end else begin
              funct3_q <= funct3_in;
              sign_q   <= a_neg_in ^ b_neg_in;
              rsign_q  <= a_neg_in;
              rem_q    <= '0;
              count_q  <= CW'(N);
              busy_q   <= 1'b1;
              state_q  <= S_RUN;
              if (is_div_in) begin
                opnd_q <= b_mag_in;
                acc_q  <= {{N{1'b0}}, a_mag_in};
              end else begin
                opnd_q <= a_mag_in;
                acc_q  <= {{N{1'b0}}, b_mag_in};
              end
            end
          end
        end
        S_RUN: begin
          if (funct3_q[2]) begin
            rem_q         <= div_rem_d;
            acc_q[N-1:0]  <= div_quo_d;
          end else begin
            acc_q <= mul_acc_d;
          end
          count_q <= count_q - CW'(1);
          if (count_q == CW'(1)) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          data_out_q <= result_d;
          done_q     <= 1'b1;
          state_q    <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign illegal  = illegal_q;
  assign data_out = data_out_q;

endmodule
